// File: rtl/ide_bus_watchdog.sv
// Watchdog for 68000 accesses to the IDE window. It drives BERR when DTACK has not
// arrived within TIMEOUT_CYCLES clocks, forwards IORDY as a strobe-extend request, and keeps timeout status.
module ide_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 400,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       osc_40mhz,
    input  logic       reset,
    input  logic       n_cs,
    input  logic       n_uds,
    input  logic       n_lds,
    input  logic       n_dtack,
    input  logic       iordy,
    input  logic       enable,
    input  logic       clear_flag,
    output logic       n_berr_drv,
    output logic       iordy_hold,
    output logic       timeout_flag,
    output logic [7:0] timeout_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_BERR,
        S_RELEASE
    } state_t;

    // Bit order in each synchroniser stage: {iordy, n_lds, n_uds, n_cs}.
    logic [3:0]       r_sync [SYNC_STAGES];
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_berr_n;
    logic             r_hold;
    logic             r_flag;
    logic [7:0]       r_tcount;

    logic w_cs_s;
    logic w_uds_s;
    logic w_lds_s;
    logic w_iordy_s;
    logic w_cycle_start;
    logic w_dtack_seen;
    logic w_at_limit;
    logic w_timeout;

    always_ff @(posedge osc_40mhz) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '1;
            end
        end else begin
            r_sync[0] <= {iordy, n_lds, n_uds, n_cs};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_cs_s        = r_sync[SYNC_STAGES-1][0];
    assign w_uds_s       = r_sync[SYNC_STAGES-1][1];
    assign w_lds_s       = r_sync[SYNC_STAGES-1][2];
    assign w_iordy_s     = r_sync[SYNC_STAGES-1][3];
    assign w_cycle_start = !w_cs_s && (!w_uds_s || !w_lds_s);
    assign w_dtack_seen  = !n_dtack;
    assign w_at_limit    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable && w_cycle_start) w_next = S_COUNT;
            end
            S_COUNT: begin
                if (w_dtack_seen)            w_next = S_RELEASE;
                else if (w_cs_s || !enable)  w_next = S_IDLE;
                else if (w_at_limit)         w_next = S_BERR;
            end
            S_BERR: begin
                if (w_cs_s) w_next = S_IDLE;
            end
            S_RELEASE: begin
                if (w_cs_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_timeout = (r_state == S_COUNT) && (w_next == S_BERR);

    always_ff @(posedge osc_40mhz) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_berr_n <= 1'b1;
            r_hold   <= 1'b0;
            r_flag   <= 1'b0;
            r_tcount <= '0;
        end else begin
            r_state  <= w_next;
            r_berr_n <= (w_next != S_BERR);
            r_hold   <= (w_next == S_COUNT) && !w_iordy_s;

            // Counter freezes in BERR/RELEASE; the limit compare keeps it from wrapping.
            if (r_state == S_COUNT && w_next == S_COUNT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (r_state == S_IDLE || w_next == S_IDLE) begin
                r_cnt <= '0;
            end

            if (w_timeout) begin
                r_flag <= 1'b1;
            end else if (clear_flag) begin
                r_flag <= 1'b0;
            end

            if (w_timeout && r_tcount != 8'hFF) begin
                r_tcount <= r_tcount + 8'd1;
            end
        end
    end

    assign n_berr_drv    = r_berr_n;
    assign iordy_hold    = r_hold;
    assign timeout_flag  = r_flag;
    assign timeout_count = r_tcount;

endmodule

// File: tb/tb_ide_bus_watchdog.sv
// Randomised self-checking bench for ide_bus_watchdog. An event-level model predicts
// the BERR timing from the access start and the DTACK arrival, and tracks the status outputs.
module tb_ide_bus_watchdog;

    localparam int T   = 16;
    localparam int SS  = 2;
    localparam int LAT = SS + 1;   // clocks from CS/strobe drive to the start of counting
    localparam int TO  = LAT + T;  // clock on which BERR is asserted if no DTACK arrives

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       n_cs = 1'b1, n_uds = 1'b1, n_lds = 1'b1, n_dtack = 1'b1;
    logic       iordy = 1'b1, enable = 1'b1, clear_flag = 1'b0;
    logic       n_berr_drv, iordy_hold, timeout_flag;
    logic [7:0] timeout_count;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  exp_count = 0;
    bit  exp_flag  = 1'b0;

    ide_bus_watchdog #(.TIMEOUT_CYCLES(T), .CNT_W(16), .SYNC_STAGES(SS)) dut (
        .osc_40mhz(clk), .reset(reset), .n_cs(n_cs), .n_uds(n_uds), .n_lds(n_lds),
        .n_dtack(n_dtack), .iordy(iordy), .enable(enable), .clear_flag(clear_flag),
        .n_berr_drv(n_berr_drv), .iordy_hold(iordy_hold), .timeout_flag(timeout_flag),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_timeout();
        exp_flag = 1'b1;
        if (exp_count < 255) exp_count++;
    endtask

    task automatic release_bus();
        n_cs = 1'b1; n_uds = 1'b1; n_lds = 1'b1; n_dtack = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        edges(3);
        n_checks++; if (n_berr_drv !== 1'b1) $display("FAIL reset_berr: got %b want 1", n_berr_drv); else n_pass++;
        n_checks++; if (iordy_hold !== 1'b0) $display("FAIL reset_hold: got %b want 0", iordy_hold); else n_pass++;
        n_checks++; if (timeout_flag !== 1'b0) $display("FAIL reset_flag: got %b want 0", timeout_flag); else n_pass++;
        n_checks++; if (timeout_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", timeout_count); else n_pass++;
        reset = 1'b0;
        edges(2);
    endtask

    // Directed boundary cases first, then random DTACK delays and strobe patterns.
    task automatic test_dtack_timeout();
        int tbl_e[5]   = '{11, 18, 19, 25, 3};
        int tbl_sel[5] = '{1, 0, 2, 0, 1};
        for (int n = 0; n < 40; n++) begin
            int e, sel;
            bit started, exp_berr;
            e   = (n < 5) ? tbl_e[n] : int'($urandom_range(3, 25));
            sel = (n < 5) ? tbl_sel[n] : int'($urandom_range(0, 3));
            started  = (sel != 3);
            exp_berr = started && (e >= TO);
            n_cs  = 1'b0;
            n_uds = !(sel == 0 || sel == 2);
            n_lds = !(sel == 1 || sel == 2);
            for (int k = 1; k <= 22; k++) begin
                edges(1);
                if (k == e) n_dtack = 1'b0;
                if (k == TO - 1) begin
                    n_checks++; if (n_berr_drv !== 1'b1) $display("FAIL berr_early n=%0d e=%0d: got %b want 1", n, e, n_berr_drv); else n_pass++;
                end
                if (k == TO) begin
                    if (exp_berr) model_timeout();
                    n_checks++; if (n_berr_drv !== !exp_berr) $display("FAIL berr_edge n=%0d e=%0d sel=%0d: got %b want %b", n, e, sel, n_berr_drv, !exp_berr); else n_pass++;
                end
                if (k == 22) begin
                    n_checks++; if (timeout_flag !== exp_flag) $display("FAIL flag n=%0d: got %b want %b", n, timeout_flag, exp_flag); else n_pass++;
                    n_checks++; if (timeout_count !== 8'(exp_count)) $display("FAIL count n=%0d: got %0d want %0d", n, timeout_count, exp_count); else n_pass++;
                    n_checks++; if (iordy_hold !== 1'b0) $display("FAIL hold_ready n=%0d: got %b want 0", n, iordy_hold); else n_pass++;
                end
            end
            release_bus();
            edges(LAT - 1);
            n_checks++; if (n_berr_drv !== !exp_berr) $display("FAIL berr_hold n=%0d: got %b want %b", n, n_berr_drv, !exp_berr); else n_pass++;
            edges(1);
            n_checks++; if (n_berr_drv !== 1'b1) $display("FAIL berr_release n=%0d: got %b want 1", n, n_berr_drv); else n_pass++;
            edges($urandom_range(1, 3));
        end
    endtask

    task automatic test_iordy();
        n_cs = 1'b0; n_uds = 1'b0; n_lds = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            edges(1);
            if (k == 5) iordy = 1'b0;
            if (k == 5 + LAT - 1) begin
                n_checks++; if (iordy_hold !== 1'b0) $display("FAIL hold_rise_early: got %b want 0", iordy_hold); else n_pass++;
            end
            if (k == 5 + LAT) begin
                n_checks++; if (iordy_hold !== 1'b1) $display("FAIL hold_rise: got %b want 1", iordy_hold); else n_pass++;
            end
            if (k == 10) iordy = 1'b1;
            if (k == 10 + LAT - 1) begin
                n_checks++; if (iordy_hold !== 1'b1) $display("FAIL hold_fall_early: got %b want 1", iordy_hold); else n_pass++;
            end
            if (k == 10 + LAT) begin
                n_checks++; if (iordy_hold !== 1'b0) $display("FAIL hold_fall: got %b want 0", iordy_hold); else n_pass++;
                iordy = 1'b0;
            end
            if (k == TO - 1) begin
                n_checks++; if (iordy_hold !== 1'b1) $display("FAIL hold_before_berr: got %b want 1", iordy_hold); else n_pass++;
            end
            if (k == TO) begin
                model_timeout();
                n_checks++; if (iordy_hold !== 1'b0) $display("FAIL hold_in_berr: got %b want 0", iordy_hold); else n_pass++;
                n_checks++; if (n_berr_drv !== 1'b0) $display("FAIL iordy_berr: got %b want 0", n_berr_drv); else n_pass++;
            end
        end
        iordy = 1'b1;
        release_bus();
        edges(LAT + 2);
    endtask

    // Dropping enable aborts the count; raising it again with the cycle still open restarts it.
    task automatic test_enable_count();
        n_cs = 1'b0; n_uds = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            edges(1);
            if (k == 8) enable = 1'b0;
            if (k == TO || k == 22) begin
                n_checks++; if (n_berr_drv !== 1'b1) $display("FAIL en_off_berr k=%0d: got %b want 1", k, n_berr_drv); else n_pass++;
                n_checks++; if (timeout_count !== 8'(exp_count)) $display("FAIL en_off_count k=%0d: got %0d want %0d", k, timeout_count, exp_count); else n_pass++;
            end
            if (k == 22) enable = 1'b1;
            if (k == 22 + T) begin
                n_checks++; if (n_berr_drv !== 1'b1) $display("FAIL en_pickup_early: got %b want 1", n_berr_drv); else n_pass++;
            end
            if (k == 23 + T) begin
                model_timeout();
                n_checks++; if (n_berr_drv !== 1'b0) $display("FAIL en_pickup_berr: got %b want 0", n_berr_drv); else n_pass++;
            end
        end
        release_bus();
        edges(LAT + 2);
    endtask

    task automatic test_enable_berr();
        n_cs = 1'b0; n_lds = 1'b0;
        edges(TO);
        model_timeout();
        n_checks++; if (n_berr_drv !== 1'b0) $display("FAIL enb_berr: got %b want 0", n_berr_drv); else n_pass++;
        enable = 1'b0;
        edges(6);
        n_checks++; if (n_berr_drv !== 1'b0) $display("FAIL enb_held: got %b want 0", n_berr_drv); else n_pass++;
        release_bus();
        edges(LAT - 1);
        n_checks++; if (n_berr_drv !== 1'b0) $display("FAIL enb_held_late: got %b want 0", n_berr_drv); else n_pass++;
        edges(1);
        n_checks++; if (n_berr_drv !== 1'b1) $display("FAIL enb_release: got %b want 1", n_berr_drv); else n_pass++;
        enable = 1'b1;
        edges(2);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 257; n++) begin
            n_cs = 1'b0; n_uds = 1'b0;
            edges(TO);
            model_timeout();
            n_checks++; if (n_berr_drv !== 1'b0) $display("FAIL b2b_berr n=%0d: got %b want 0", n, n_berr_drv); else n_pass++;
            release_bus();
            edges(LAT);
        end
        n_checks++; if (timeout_count !== 8'(exp_count)) $display("FAIL b2b_sat: got %0d want %0d", timeout_count, exp_count); else n_pass++;
        n_cs = 1'b0; n_lds = 1'b0;
        edges(TO - 1);
        clear_flag = 1'b1;
        edges(1);
        clear_flag = 1'b0;
        model_timeout();
        n_checks++; if (timeout_flag !== exp_flag) $display("FAIL clear_vs_set: got %b want %b", timeout_flag, exp_flag); else n_pass++;
        n_checks++; if (timeout_count !== 8'(exp_count)) $display("FAIL sat_hold: got %0d want %0d", timeout_count, exp_count); else n_pass++;
        release_bus();
        edges(LAT + 1);
        clear_flag = 1'b1;
        edges(1);
        clear_flag = 1'b0;
        exp_flag = 1'b0;
        n_checks++; if (timeout_flag !== exp_flag) $display("FAIL clear_flag: got %b want %b", timeout_flag, exp_flag); else n_pass++;
        n_checks++; if (timeout_count !== 8'(exp_count)) $display("FAIL clear_keeps_count: got %0d want %0d", timeout_count, exp_count); else n_pass++;
    endtask

    task automatic test_reset_in_berr();
        n_cs = 1'b0; n_uds = 1'b0;
        edges(TO + 1);
        model_timeout();
        n_checks++; if (n_berr_drv !== 1'b0) $display("FAIL rb_berr: got %b want 0", n_berr_drv); else n_pass++;
        reset = 1'b1;
        edges(1);
        exp_flag = 1'b0; exp_count = 0;
        n_checks++; if (n_berr_drv !== 1'b1) $display("FAIL rb_release: got %b want 1", n_berr_drv); else n_pass++;
        n_checks++; if (timeout_flag !== exp_flag) $display("FAIL rb_flag: got %b want %b", timeout_flag, exp_flag); else n_pass++;
        n_checks++; if (timeout_count !== 8'(exp_count)) $display("FAIL rb_count: got %0d want %0d", timeout_count, exp_count); else n_pass++;
        reset = 1'b0;
        release_bus();
        edges(TO + 2);
        n_checks++; if (n_berr_drv !== 1'b1) $display("FAIL rb_idle: got %b want 1", n_berr_drv); else n_pass++;
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dtack_timeout();
        test_iordy();
        test_enable_count();
        test_enable_berr();
        test_back_to_back();
        test_reset_in_berr();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
